// File: rtl/sa_result_writer.sv
// Result drain for the 3x3 systolic array: snapshots nine PE results on a start
// pulse and streams them, optionally saturated to 8 bits, into the result memory.
module sa_result_writer #(
  parameter int RES_W  = 16,
  parameter bit SAT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [5:0]       base_addr,
  input  logic [RES_W-1:0] result_1,
  input  logic [RES_W-1:0] result_2,
  input  logic [RES_W-1:0] result_3,
  input  logic [RES_W-1:0] result_4,
  input  logic [RES_W-1:0] result_5,
  input  logic [RES_W-1:0] result_6,
  input  logic [RES_W-1:0] result_7,
  input  logic [RES_W-1:0] result_8,
  input  logic [RES_W-1:0] result_9,
  output logic             busy_o,
  output logic             is_done_o,
  output logic [5:0]       addr,
  output logic [7:0]       wdata,
  output logic             we
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [5:0]       base_q, base_d;
  logic [RES_W-1:0] buf_q [9];
  logic [RES_W-1:0] buf_d [9];
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             we_q, we_d;
  logic [5:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [3:0]       nxt_cnt;
  logic [RES_W-1:0] res_in [9];

  // Signed saturation to [-128,127] (or plain truncation) of one PE result.
  function automatic logic [7:0] conv(input logic [RES_W-1:0] x);
    logic signed [31:0] xe;
    xe = 32'(signed'(x));
    if (SAT_EN == 1'b0) begin
      conv = x[7:0];
    end else if (xe > 32'sd127) begin
      conv = 8'h7F;
    end else if (xe < -32'sd128) begin
      conv = 8'h80;
    end else begin
      conv = x[7:0];
    end
  endfunction

  assign res_in[0] = result_1;
  assign res_in[1] = result_2;
  assign res_in[2] = result_3;
  assign res_in[3] = result_4;
  assign res_in[4] = result_5;
  assign res_in[5] = result_6;
  assign res_in[6] = result_7;
  assign res_in[7] = result_8;
  assign res_in[8] = result_9;

  // Next-state and next-output logic; outputs are computed one edge ahead so the
  // first write appears in the cycle right after the start edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    for (int i = 0; i < 9; i++) begin
      buf_d[i] = buf_q[i];
    end
    busy_d  = busy_q;
    done_d  = done_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    nxt_cnt = cnt_q + 4'd1;

    case (state_q)
      IDLE: begin
        if (en) begin
          for (int i = 0; i < 9; i++) begin
            buf_d[i] = res_in[i];
          end
          base_d  = base_addr;
          cnt_d   = 4'd0;
          state_d = WRITE;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          we_d    = 1'b1;
          addr_d  = base_addr;
          wdata_d = conv(res_in[0]);
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (cnt_q == 4'd8) begin
          state_d = DONE;
          we_d    = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d   = nxt_cnt;
          addr_d  = base_q + {2'b00, nxt_cnt};
          wdata_d = conv(buf_q[nxt_cnt]);
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
        done_d  = 1'b0;
        busy_d  = 1'b0;
        we_d    = 1'b0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
        done_d  = 1'b0;
        busy_d  = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  // State, snapshot buffer and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      base_q  <= 6'd0;
      for (int i = 0; i < 9; i++) begin
        buf_q[i] <= '0;
      end
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 6'd0;
      wdata_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      for (int i = 0; i < 9; i++) begin
        buf_q[i] <= buf_d[i];
      end
      busy_q  <= busy_d;
      done_q  <= done_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy_o    = busy_q;
  assign is_done_o = done_q;
  assign we        = we_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;

endmodule

// File: doc/sa_result_writer.md
Name: sa_result_writer

Overview:
- Drain-side counterpart of the weight loading path for the 3x3 systolic array.
- Snapshots the nine PE accumulator results on a start pulse, then writes them to the 64-entry, 8-bit result memory one word per cycle.
- Optionally saturates each signed result to 8 bits before the write.
- Sits between the SA output ports and the result memory write port; the top-level controller sequences it.

Parameters:
- RES_W, 16: width of each signed PE result, valid range 8..32.
- SAT_EN, 1: 1 = signed saturation to [-128,127]; 0 = truncation to bits [7:0].

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  start pulse; sampled only in IDLE.
- base_addr  input  6  first memory address of the 9-word block; sampled with en.
- result_1 .. result_9  input  RES_W each  signed PE results, row-major (PE 1 to PE 9).
- busy_o  output  1  high whenever state is not IDLE.
- is_done_o  output  1  one-cycle pulse after the last write.
- addr  output  6  memory write address.
- wdata  output  8  memory write data.
- we  output  1  memory write enable.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, cnt = 0.
  - All nine buffer entries = 0; base register = 0.
  - busy_o = 0, is_done_o = 0, we = 0, addr = 0, wdata = 0.
- All outputs are registered. No combinational path exists from any input to any output.
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - If en = 1 at a rising edge, then on that same edge: load result_1..9 into buf[0..8], load base_addr into the base register, set cnt = 0, go to WRITE.
  - If en = 0, stay in IDLE.
- WRITE:
  - Runs for exactly 9 cycles, cnt = 0..8.
  - Each cycle: we = 1, addr = (base + cnt) mod 64, wdata = conv(buf[cnt]).
  - Address wraps past 63 back to 0; no error is flagged.
  - After the cnt = 8 cycle, go to DONE.
- DONE:
  - One cycle: is_done_o = 1, we = 0, busy_o = 1.
  - Then return to IDLE.
- Latency:
  - en sampled at edge k gives the first write (we = 1) in the cycle after edge k.
  - is_done_o is asserted in the cycle after the 9th write.
  - Start to done is 10 cycles; minimum spacing between two starts is 11 cycles.
- en during WRITE or DONE is ignored. It is not queued, and the buffer and base register do not change.
- en held high continuously: a new transfer starts on the first IDLE edge after DONE.
- result inputs may change freely after the capture edge. Writes always use the snapshot.
- conv(x):
  - SAT_EN = 1: x > 127 gives 8'h7F; x < -128 gives 8'h80; otherwise x[7:0].
  - SAT_EN = 0: x[7:0].
  - x is treated as two's complement, RES_W bits wide.
- When we = 0, addr and wdata hold their last values. Downstream must ignore them.
- Reset mid-transfer:
  - Immediate abort, all outputs go to their reset values.
  - No is_done_o pulse for the aborted transfer.
  - Memory contents already written stay in place.

Test Plan:
- Basic drain:
  - Stimulus: SAT_EN = 1; results 1..9 = 1, 2, ..., 9; base_addr = 0; en pulse.
  - Response: we high for 9 consecutive cycles starting 1 cycle after en; addr 0..8, wdata 1..9; is_done_o pulses at cycle 10; busy_o high for cycles 1..10.
- Saturation:
  - Stimulus: results = 300, -300, 127, -128, 128, -129, 0, -1, 16'h7FFF.
  - SAT_EN = 1 response: wdata = 7F, 80, 7F, 80, 7F, 80, 00, FF, 7F.
  - SAT_EN = 0 response: wdata = 2C, D4, 7F, 80, 80, 7F, 00, FF, FF.
- Wrap and snapshot:
  - Stimulus: base_addr = 60; after the capture edge, change all results to 16'hAAAA.
  - Response: addr sequence 60, 61, 62, 63, 0, 1, 2, 3, 4; wdata reflects the captured values, not AAAA.
- Busy start:
  - Stimulus: en pulse at write cycle 4, and again during DONE.
  - Response: no restart, addr sequence unbroken, a single is_done_o pulse.
  - Follow-up: en held high continuously gives back-to-back transfers 11 cycles apart.
- Reset mid-operation:
  - Stimulus: drop rst asynchronously during write cycle 5, mid-clock.
  - Response: we, busy_o, addr and wdata go to 0 immediately; no is_done_o.
  - After release, a new en produces a normal 9-write transfer.
